// File: rtl/div_unit.sv
// div_unit: multicycle 32-bit restoring divider (quotient on lo, remainder on hi).
// One accept cycle, 32 shift-subtract steps, one fix-up cycle; a zero divisor
// pulses divZero instead of starting.
// Optional feature macro: DIV_UNSIGNED_EN adds the divUnsigned port (divu support).
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
    input  logic             divUnsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    localparam int unsigned     CntW   = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] amag_q, amag_d;   // |a|, shifted out MSB-first into rem
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   trial;

`ifdef DIV_UNSIGNED_EN
    assign op_signed = ~divUnsigned;
`else
    assign op_signed = 1'b1;
`endif

    assign a_neg = op_signed & a[WIDTH-1];
    assign b_neg = op_signed & b[WIDTH-1];

    // Next-state: accept/zero-check in idle, one restoring step per run cycle, sign fix-up.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        amag_d  = amag_q;
        bmag_d  = bmag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        // Trial subtract on the shifted remainder; WIDTH+1 bits so the borrow is visible.
        trial   = {rem_q, amag_q[WIDTH-1]} - {1'b0, bmag_q};

        case (state_q)
            StIdle: begin
                if (divControl) begin
                    if (b == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        amag_d  = a_neg ? -a : a;
                        bmag_d  = b_neg ? -b : b;
                        rneg_d  = a_neg;
                        qneg_d  = a_neg ^ b_neg;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                amag_d = {amag_q[WIDTH-2:0], 1'b0};
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], amag_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntMax) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // -2^31 / -1 wraps back to 0x80000000 naturally through the negate.
                lo_d    = qneg_q ? -quo_q : quo_q;
                hi_d    = rneg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            amag_q  <= '0;
            bmag_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            amag_q  <= amag_d;
            bmag_q  <= bmag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // Busy covers run/fix plus the done cycle, so it drops one edge after the result write.
    always_comb begin
        busy    = (state_q != StIdle) | done_q;
        done    = done_q;
        divZero = dz_q;
        hi      = hi_q;
        lo      = lo_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit against a plain-arithmetic reference.
// Define DIV_UNSIGNED_EN to also exercise the divu path.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        divControl = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
`ifdef DIV_UNSIGNED_EN
    logic        divUnsigned = 1'b0;
`endif
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divZero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .divControl (divControl),
        .a          (a),
        .b          (b),
`ifdef DIV_UNSIGNED_EN
        .divUnsigned(divUnsigned),
`endif
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .divZero    (divZero)
    );

    always #5 clk = ~clk;

    // Reference: truncating division, remainder follows the dividend.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv, input logic uns,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (uns) begin
            q = av / bv;
            r = av % bv;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            sa = av;
            sb = bv;
            q  = sa / sb;
            r  = sa % sb;
        end
    endfunction

    // Launch one op with a single-cycle start; report done latency (edges after accept),
    // number of sampled busy cycles, and the result. lat = -1 if done never arrives.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic uns,
                         output int lat, output int bcnt,
                         output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        a          = av;
        b          = bv;
`ifdef DIV_UNSIGNED_EN
        divUnsigned = uns;
`endif
        if (uns) begin end
        divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        a          = $urandom;
        b          = $urandom;
        lat  = -1;
        bcnt = busy ? 1 : 0;
        h    = 'x;
        l    = 'x;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                h   = hi;
                l   = lo;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({hi, lo, busy, done, divZero} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, required all 0",
                     hi, lo, busy, done, divZero);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic [31:0] h, l;
        do_op(32'd100, 32'd7, 1'b0, lat, bcnt, h, l);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, required 33", lat);
        end
        checks++;
        if (l !== 32'd14 || h !== 32'd2) begin
            errors++;
            $display("FAIL basic_result: lo=%0d hi=%0d, required lo=14 hi=2", l, h);
        end
        checks++;
        if (bcnt !== 34) begin
            errors++;
            $display("FAIL basic_busy: busy %0d cycles, required 34", bcnt);
        end
    endtask

    task automatic test_signs;
        int lat, bcnt;
        logic [31:0] h, l;
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcnt, h, l);
        checks++;
        if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL neg_dividend: lo=%h hi=%h, required lo=fffffffd hi=ffffffff", l, h);
        end
        do_op(32'd7, 32'hFFFF_FFFE, 1'b0, lat, bcnt, h, l);
        checks++;
        if (l !== 32'hFFFF_FFFD || h !== 32'd1) begin
            errors++;
            $display("FAIL neg_divisor: lo=%h hi=%h, required lo=fffffffd hi=00000001", l, h);
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        logic [31:0] h, l;
        logic seen_bad;
        do_op(32'd100, 32'd7, 1'b0, lat, bcnt, h, l);
        @(negedge clk);
        a = 32'd5;
        b = 32'd0;
        divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        checks++;
        if (divZero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL dz_pulse: dz=%b busy=%b done=%b, required 1/0/0", divZero, busy, done);
        end
        seen_bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (divZero || busy || done) seen_bad = 1'b1;
        end
        checks++;
        if (seen_bad !== 1'b0) begin
            errors++;
            $display("FAIL dz_after: dz/busy/done activity after pulse, required none");
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL dz_hold: hi=%0d lo=%0d, required hi=2 lo=14", hi, lo);
        end
    endtask

    task automatic test_overflow;
        int lat, bcnt;
        logic [31:0] h, l;
        logic dz_seen;
        dz_seen = 1'b0;
        fork
            do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt, h, l);
            repeat (40) @(negedge clk) if (divZero) dz_seen = 1'b1;
        join
        checks++;
        if (l !== 32'h8000_0000 || h !== 32'd0 || dz_seen !== 1'b0 || lat !== 33) begin
            errors++;
            $display("FAIL overflow: lo=%h hi=%h dz=%b lat=%0d, required 80000000/0/0/33",
                     l, h, dz_seen, lat);
        end
    endtask

    task automatic test_ignore_restart;
        int lat;
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            if (n == 5) begin
                a = 32'd1;
                b = 32'd1;
                divControl = 1'b1;
            end
            @(negedge clk);
            divControl = 1'b0;
            if (done) begin
                lat = n;
                checks++;
                if (lo !== 32'd14 || hi !== 32'd2) begin
                    errors++;
                    $display("FAIL restart_result: lo=%0d hi=%0d, required 14/2", lo, hi);
                end
            end
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL restart_latency: got %0d, required 33", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        logic late_done;
        @(negedge clk);
        a = 32'd1000;
        b = 32'd3;
        divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: hi=%h lo=%h busy=%b done=%b, required all 0",
                     hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        late_done = 1'b0;
        repeat (40) @(negedge clk) if (done || busy) late_done = 1'b1;
        checks++;
        if (late_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: done/busy after reset, required none");
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q, r;
        int lat;
        logic gap;
        @(negedge clk);
        a = 32'd1234567;
        b = 32'hFFFF_FF00;
        divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (done) lat = n;
        end
        // Done cycle: request the next op so it is accepted at E34.
        a = 32'hDEAD_BEEF;
        b = 32'd97;
        divControl = 1'b1;
        @(negedge clk);
        divControl = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b after E34 start, required 1", busy);
        end
        lat = -1;
        gap = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (!busy) gap = 1'b1;
            if (done) lat = n;
        end
        model(32'hDEAD_BEEF, 32'd97, 1'b0, q, r);
        checks++;
        if (lat !== 33 || gap !== 1'b0 || lo !== q || hi !== r) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d gap=%b lo=%h hi=%h, required 33/0/%h/%h",
                     lat, gap, lo, hi, q, r);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, bcnt;
        logic [31:0] h, l, av, bv, q, r;
        for (int i = 0; i < 24; i++) begin
            av = $urandom;
            case (i % 4)
                0: bv = $urandom_range(1, 15);
                1: bv = -$urandom_range(1, 300);
                2: bv = $urandom >> $urandom_range(0, 30);
                default: bv = $urandom;
            endcase
            if (bv == 32'd0) bv = 32'd3;
            model(av, bv, 1'b0, q, r);
            do_op(av, bv, 1'b0, lat, bcnt, h, l);
            checks++;
            if (lat !== 33 || l !== q || h !== r) begin
                errors++;
                $display("FAIL random_%0d: %h/%h lat=%0d lo=%h hi=%h, required 33 lo=%h hi=%h",
                         i, av, bv, lat, l, h, q, r);
            end
        end
    endtask

`ifdef DIV_UNSIGNED_EN
    task automatic test_unsigned;
        int lat, bcnt;
        logic [31:0] h, l, av, bv, q, r;
        do_op(32'hFFFF_FFFF, 32'd2, 1'b1, lat, bcnt, h, l);
        checks++;
        if (l !== 32'h7FFF_FFFF || h !== 32'd1) begin
            errors++;
            $display("FAIL divu: lo=%h hi=%h, required 7fffffff/1", l, h);
        end
        do_op(32'hFFFF_FFFF, 32'd2, 1'b0, lat, bcnt, h, l);
        checks++;
        if (l !== 32'd0 || h !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_signed_sel: lo=%h hi=%h, required 0/ffffffff", l, h);
        end
        for (int i = 0; i < 8; i++) begin
            av = $urandom;
            bv = $urandom >> $urandom_range(0, 31);
            if (bv == 32'd0) bv = 32'd5;
            model(av, bv, 1'b1, q, r);
            do_op(av, bv, 1'b1, lat, bcnt, h, l);
            checks++;
            if (l !== q || h !== r) begin
                errors++;
                $display("FAIL divu_random_%0d: lo=%h hi=%h, required %h/%h", i, l, h, q, r);
            end
        end
        divUnsigned = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_ignore_restart();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef DIV_UNSIGNED_EN
        test_unsigned();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multicycle signed 32-bit integer divider serving the CPU datapath's `div` path. The control unit pulses `divControl`, and the block iterates a restoring shift-subtract over 32 cycles. It then writes quotient/remainder to its LO/HI outputs, which feed the HI/LO registers and `srcData` mux. A zero divisor raises a one-cycle `divZero` flag consumed by the exception sequencing (`excpControl`).

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `divControl`  input  1  start request, sampled each rising edge while idle.
- `a`  input  32  dividend (register A value).
- `b`  input  32  divisor (register B value).
- `divUnsigned`  input  1  exists only with `DIV_UNSIGNED_EN`; 1 selects `divu`.
- `hi`  output  32  remainder.
- `lo`  output  32  quotient.
- `busy`  output  1  high from the accepted start through the result write.
- `done`  output  1  one-cycle pulse when `hi`/`lo` are updated.
- `divZero`  output  1  one-cycle pulse for divide by zero.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**: on `divControl=1`:
  - If `b==0`: assert `divZero` for one cycle and stay in IDLE. `hi`/`lo` hold; `done` is not asserted.
  - Otherwise: latch |a|, |b|, sign(a), sign(a)^sign(b), clear the 64-bit partial remainder/quotient register, and go to RUN with the iteration counter at 0.
- **RUN**: one restoring step per cycle. Shift {rem,quo} left by 1 and trial-subtract |b| from rem. If the result is non-negative, keep it and set quo[0]=1. The counter increments; after the step with counter==31, go to FIX.
- **FIX**:
  - Quotient: negate if the sign flag is set.
  - Remainder: negate if the dividend was negative.
  - Register both into `lo`/`hi`, pulse `done`, and return to IDLE.
- Quotient truncates toward zero; the remainder takes the dividend's sign.
- -2^31 / -1 yields `lo`=0x80000000, `hi`=0, with no flag.
- `divControl` during RUN/FIX is ignored. There is no queuing, and operands are not re-sampled.
- `a`/`b` only need to be valid on the accepting edge.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `divZero`=0, state IDLE, counter 0.
- Reset assertion at any point, including mid-RUN, clears everything immediately and asynchronously. The in-flight result is discarded.
- The accepting edge is E0. `busy` is high after E0, RUN occupies E1..E32, and FIX resolves at E33.
- `hi`/`lo` are updated and `done`=1 after E33, for exactly one cycle. `busy` falls after E34.
- A new start is accepted at E34 at the earliest, giving 34 cycles per operation.
- `divZero` is high for the single cycle after the accepting edge; `busy` stays 0.
- `hi`/`lo` change only in FIX or on reset.

## Configuration
- `DIV_UNSIGNED_EN` defined:
  - The `divUnsigned` port is present.
  - When it is 1 at the accepting edge, operands are used as unsigned magnitudes and no sign fix-up occurs in FIX.
  - Divide-by-zero detection is identical.
- Not defined: no `divUnsigned` port, and every operation is signed.

## Test plan
- a=100, b=7, one-cycle start -> `done` pulse exactly 33 edges after the accept; `lo`=14, `hi`=2; `busy` high for 34 cycles.
- a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; a=7, b=0xFFFFFFFE -> `lo`=0xFFFFFFFD, `hi`=1.
- Prior result hi=2/lo=14, then a=5, b=0, start -> `divZero` one-cycle pulse next cycle; `done` and `busy` stay 0; `hi`/`lo` remain 2/14.
- a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, `divZero`=0.
- Start 100/7, re-pulse `divControl` at cycle 5 with a=1, b=1 -> ignored, still `lo`=14 at cycle 33. Start again, drop `reset` at cycle 10 -> `hi`/`lo`/`busy`/`done`=0 immediately, no later `done`.
- With `DIV_UNSIGNED_EN`: a=0xFFFFFFFF, b=2, `divUnsigned`=1 -> `lo`=0x7FFFFFFF, `hi`=1. With `divUnsigned`=0 -> `lo`=0, `hi`=0xFFFFFFFF.
